// File: rtl/bit_extractor_seq_if.sv
// bit_extractor_seq_if: sample input and message output bundle for the LSB extractor.
interface bit_extractor_seq_if #(
  parameter int BPS = 24,
  parameter int MESSAGE_LENGTH = 88
);
  logic in_enable;
  logic [BPS-1:0] in_frame;
  logic in_valid;
  logic [MESSAGE_LENGTH-1:0] out_message;
  logic out_valid;
  logic [9:0] out_bit_count;
  logic out_busy;
  modport master (
    output in_enable, in_frame, in_valid,
    input out_message, out_valid, out_bit_count, out_busy
  );
  modport slave (
    input in_enable, in_frame, in_valid,
    output out_message, out_valid, out_bit_count, out_busy
  );
endinterface

// File: rtl/bit_extractor_seq.sv
// bit_extractor_seq: rebuilds an MSB-first message from sample LSBs, one bit per in_valid rise.
// Define BIT_EXTRACTOR_SYNC_EN to hunt for SYNC_WORD before each word.
module bit_extractor_seq #(
  parameter int BPS = 24,
  parameter int MESSAGE_LENGTH = 88,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input logic in_clk,
  input logic in_rst,
  bit_extractor_seq_if.slave bus
);
  localparam int ML = MESSAGE_LENGTH;
`ifdef BIT_EXTRACTOR_SYNC_EN
  typedef enum logic [1:0] {IDLE, SYNC, COLLECT} state_t;
  localparam state_t START = SYNC;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
  localparam state_t START = COLLECT;
`endif
  state_t state, state_nxt;
  logic valid_d;
  logic [ML-1:0] shift;
  logic [ML-1:0] message;
  logic [9:0] count;
  logic valid_q;
  logic strike;
  logic bit_in;
  logic last;
  logic done;
  assign strike = bus.in_valid & ~valid_d;
  assign bit_in = bus.in_frame[0];
  assign last = count == 10'(ML - 1);
  assign done = state == COLLECT && bus.in_enable && strike && last;
`ifdef BIT_EXTRACTOR_SYNC_EN
  logic [7:0] hist;
  logic sync_hit;
  logic unused;
  assign sync_hit = state == SYNC && strike && {hist[6:0], bit_in} == SYNC_WORD;
  assign unused = ^bus.in_frame[BPS-1:1];
`else
  logic unused;
  assign unused = ^{bus.in_frame[BPS-1:1], SYNC_WORD};
`endif
  // later assignments win: disable overrides everything
  always_comb begin
    state_nxt = state;
    if (state == IDLE || done) state_nxt = START;
`ifdef BIT_EXTRACTOR_SYNC_EN
    if (sync_hit) state_nxt = COLLECT;
`endif
    if (!bus.in_enable) state_nxt = IDLE;
  end
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) state <= IDLE;
    else state <= state_nxt;
  // valid_d resets high so a level already present at release is not a sample
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid_d <= 1'b1;
      shift <= '0;
      count <= '0;
      message <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_d <= bus.in_valid;
      valid_q <= done;
      if (done) message <= {shift[ML-2:0], bit_in};
      if (!bus.in_enable || state != COLLECT) begin
        shift <= '0;
        count <= '0;
      end else if (strike) begin
        shift <= {shift[ML-2:0], bit_in};
        count <= last ? '0 : count + 10'd1;
      end
    end
  end
`ifdef BIT_EXTRACTOR_SYNC_EN
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) hist <= '0;
    else if (!bus.in_enable || state != SYNC) hist <= '0;
    else if (strike) hist <= {hist[6:0], bit_in};
`endif
  assign bus.out_message = message;
  assign bus.out_valid = valid_q;
  assign bus.out_bit_count = count;
  assign bus.out_busy = state != IDLE;
endmodule

// File: tb/tb_bit_extractor_seq.sv
// tb_bit_extractor_seq: directed LSB streams with a word scoreboard checked on out_valid.
module tb_bit_extractor_seq;
  localparam int BPS = 24;
  localparam int ML = 8;
  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [ML-1:0] q[$];
  always #5 in_clk = ~in_clk;
  bit_extractor_seq_if #(.BPS(BPS), .MESSAGE_LENGTH(ML)) bus ();
  bit_extractor_seq #(.BPS(BPS), .MESSAGE_LENGTH(ML)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus(bus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge in_clk) begin
    if (bus.out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got message %0h with no word expected", bus.out_message);
      end else begin
        logic [ML-1:0] exp;
        exp = q.pop_front();
        if (bus.out_message !== exp) begin
          errors++;
          $display("FAIL word: got %0h expected %0h", bus.out_message, exp);
        end
      end
    end
  end
  task automatic send_bit(input logic b, input int hold, input logic counts);
    logic [BPS-1:0] f;
    f = BPS'($urandom);
    f[0] = b;
    bus.in_frame = f;
    bus.in_valid = 1'b1;
    @(negedge in_clk);
    if (counts) exp_cnt = (exp_cnt + 1) % ML;
    check("bit_count", 32'(bus.out_bit_count), exp_cnt);
    check("pulse_timing", 32'(bus.out_valid), 32'(counts && exp_cnt == 0));
    repeat (hold - 1) @(negedge in_clk);
    bus.in_valid = 1'b0;
    @(negedge in_clk);
  endtask
  task automatic send_word(input logic [ML-1:0] w, input int hold);
    q.push_back(w);
    for (int i = ML - 1; i >= 0; i--) send_bit(w[i], hold, 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [7:0] sw;
    bus.in_enable = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_frame = '0;
    repeat (3) @(negedge in_clk);
    check("rst_message", 32'(bus.out_message), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_count", 32'(bus.out_bit_count), 0);
    check("rst_busy", 32'(bus.out_busy), 0);
    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);
    check("held_valid_count", 32'(bus.out_bit_count), 0);
    check("held_valid_pulse", 32'(bus.out_valid), 0);
    check("busy_after_enable", 32'(bus.out_busy), 1);
    bus.in_valid = 1'b0;
    @(negedge in_clk);
`ifdef BIT_EXTRACTOR_SYNC_EN
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    sw = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(sw[i], 1, 1'b0);
    send_word(8'hC3, 1);
    repeat (3) @(negedge in_clk);
    check("msg_after_sync", 32'(bus.out_message), 32'h0C3);
    check("count_in_sync", 32'(bus.out_bit_count), 0);
`else
    sw = 8'h00;
    send_word(8'hB2, 1);
    check("msg_b2_hold", 32'(bus.out_message), 32'h0B2);
    send_word(8'h3C, 5);
    send_word(8'h5A, 5);
    for (int i = 0; i < 5; i++) send_bit(sw[i] ^ i[0], 1, 1'b1);
    bus.in_enable = 1'b0;
    @(negedge in_clk);
    check("abort_count", 32'(bus.out_bit_count), 0);
    check("abort_busy", 32'(bus.out_busy), 0);
    check("abort_keeps_msg", 32'(bus.out_message), 32'h05A);
    exp_cnt = 0;
    bus.in_enable = 1'b1;
    @(negedge in_clk);
    check("reenable_busy", 32'(bus.out_busy), 1);
    send_word(8'hFF, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1, 1'b1);
    @(posedge in_clk);
    #2 in_rst = 1'b1;
    #1;
    check("async_rst_message", 32'(bus.out_message), 0);
    check("async_rst_count", 32'(bus.out_bit_count), 0);
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_busy", 32'(bus.out_busy), 0);
    @(negedge in_clk);
    in_rst = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge in_clk);
`endif
    repeat (2) @(negedge in_clk);
    check("pending_words", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_extractor_seq.md
# bit_extractor_seq

Receive-side counterpart of the LSB embedding stage. Consumes stego samples one at a time, takes bit 0 of each, and rebuilds the hidden message MSB-first into a MESSAGE_LENGTH-bit word. Presents the word with a one-cycle valid pulse. Sits directly downstream of the embedder: its in_frame/in_valid connect to the embedder's out_frame/out_ready.

## Interface
- BPS, 24, bits per sample
- MESSAGE_LENGTH, 88, message bits per word (2..1023)
- SYNC_WORD, 8'hA5, sync pattern; used only with BIT_EXTRACTOR_SYNC_EN
- in_clk  input  1  clock, all logic on rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_enable  input  1  active high; low aborts and holds block in IDLE
- in_frame  input  BPS  stego sample; only bit 0 is used
- in_valid  input  1  sample-ready level; each 0->1 transition delivers one sample
- out_message  output  MESSAGE_LENGTH  last completed message, first received bit in MSB
- out_valid  output  1  one-cycle pulse, out_message updated
- out_bit_count  output  10  bits collected for the current word
- out_busy  output  1  high in SYNC or COLLECT

## Operation
- Sample strike: registered in_valid_d; strike = in_valid & ~in_valid_d. A level held high for N cycles counts once. in_valid_d resets to 1, so a level already high at reset release is not a sample.
- On a strike, bit = in_frame[0], sampled at that clock edge.
- States: IDLE, SYNC (macro only), COLLECT.
- IDLE:
  - count = 0, shift register cleared, strikes ignored.
  - in_enable=1 -> COLLECT next edge; -> SYNC if macro defined.
- COLLECT:
  - On strike: shift <= {shift[ML-2:0], bit}; count += 1.
  - On the strike that makes count = MESSAGE_LENGTH:
    - out_message <= {shift[ML-2:0], bit}
    - out_valid <= 1
    - count <= 0
    - stay in COLLECT (or -> SYNC with macro)
  - No sample is lost across word boundaries.
- in_enable=0 in any state -> IDLE next edge. Partial word discarded; out_message retains the last completed word. in_enable takes priority over a simultaneous strike.
- out_valid is high for exactly one cycle per completed word.

## Timing
- Reset values:
  - out_message = 0, out_valid = 0, out_bit_count = 0, out_busy = 0
  - state = IDLE, in_valid_d = 1
- Strike latency: in_valid rises before edge k; bit captured at edge k; out_bit_count reflects it after edge k.
- Word latency: out_valid is high in the cycle after the edge that captures bit MESSAGE_LENGTH-1. out_message is valid in the same cycle and holds until the next word.
- Maximum rate: one sample per 2 cycles (in_valid must return low for at least one cycle between samples).
- Reset mid-word: immediate clear, no out_valid.

## Configuration
- BIT_EXTRACTOR_SYNC_EN defined:
  - SYNC state holds an 8-bit LSB history that shifts on every strike.
  - When history == SYNC_WORD (including the current bit), go to COLLECT next edge with count = 0. The sync bits are not part of the message.
  - After each completed word, return to SYNC.
  - out_bit_count stays 0 while in SYNC.
- Not defined:
  - SYNC state and history register are absent; SYNC_WORD is unused.
  - IDLE goes directly to COLLECT, and words are back-to-back.

## Test plan
- Reset release with in_valid held high -> no capture; out_bit_count=0, out_valid=0.
- MESSAGE_LENGTH=8, enable, 8 strikes with LSBs 1,0,1,1,0,0,1,0 -> out_message=8'hB2, single out_valid pulse the cycle after the 8th capture.
- in_valid held high 5 cycles per sample, 16 samples -> exactly 2 words and 2 pulses, out_bit_count wraps 7->0.
- in_enable dropped after 5 bits, then 8 fresh bits 0xFF -> out_message=8'hFF; no pulse for the aborted word.
- in_rst asserted asynchronously after 3 bits -> all outputs 0 immediately (before the next clock edge).
- Macro on: LSB stream 0,1, then A5 (1010_0101), then C3 -> exactly one pulse, out_message=8'hC3; bits before the sync are ignored.
